// File: rtl/hls_seq_pkg.sv
// hls_seq_pkg: shared types and helpers for the Bambu run sequencer.
// Holds the FSM state encoding, default widths and the saturating increment
// used by the per-channel latency counters and the run watchdog.
package hls_seq_pkg;

    localparam int NUM_CH_DEF  = 2;
    localparam int CNT_W_DEF   = 32;
    localparam int RUNS_W_DEF  = 16;
    localparam int RST_CYC_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_WAIT,
        S_RECORD,
        S_END
    } seq_state_t;

    // Increment value by one, sticking at 2^width-1 (width below 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] limit;
        limit = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= limit) ? limit : value + 64'd1;
    endfunction

endpackage

// File: rtl/hls_seq_lat_ch.sv
// hls_seq_lat_ch: latency measurement for one accelerator channel.
// Tracks the pending bit, the running latency counter and the captured value
// of the current run, and keeps the last latency. When HLS_SEQ_STATS_EN is
// defined it also keeps min/max/sum statistics; otherwise those read as 0.
module hls_seq_lat_ch
    import hls_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RUNS_W = RUNS_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     wait_en,
    input  logic                     record,
    input  logic                     done,
    output logic                     pending,
    output logic [CNT_W-1:0]         lat_last,
    output logic [CNT_W-1:0]         lat_min,
    output logic [CNT_W-1:0]         lat_max,
    output logic [CNT_W+RUNS_W-1:0]  lat_sum
);

    logic             pending_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cap_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lat_last_reg;

    assign cnt_next = CNT_W'(sat_inc(64'(cnt_reg), CNT_W));

    // Still waiting after this cycle's done sample: the FSM decides on this.
    assign pending = pending_reg & ~done;

    // Run-time counter: starts at 1 in the start cycle, captures on first done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_reg <= 1'b0;
            cnt_reg     <= '0;
            cap_reg     <= '0;
        end else if (start) begin
            cnt_reg     <= CNT_W'(1);
            pending_reg <= ~done;
            if (done) begin
                cap_reg <= CNT_W'(1);
            end
        end else if (wait_en && pending_reg) begin
            cnt_reg <= cnt_next;
            if (done) begin
                cap_reg     <= cnt_next;
                pending_reg <= 1'b0;
            end
        end else if (clear) begin
            pending_reg <= 1'b0;
        end
    end

    // Last-latency register, loaded once per completed run.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            lat_last_reg <= '0;
        end else if (record) begin
            lat_last_reg <= cap_reg;
        end
    end

    assign lat_last = lat_last_reg;

`ifdef HLS_SEQ_STATS_EN
    logic [CNT_W-1:0]        lat_min_reg;
    logic [CNT_W-1:0]        lat_max_reg;
    logic [CNT_W+RUNS_W-1:0] lat_sum_reg;

    // Running min/max/sum over completed runs of the current sequence.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            lat_min_reg <= '1;
            lat_max_reg <= '0;
            lat_sum_reg <= '0;
        end else if (record) begin
            if (cap_reg < lat_min_reg) begin
                lat_min_reg <= cap_reg;
            end
            if (cap_reg > lat_max_reg) begin
                lat_max_reg <= cap_reg;
            end
            lat_sum_reg <= lat_sum_reg + (CNT_W+RUNS_W)'(cap_reg);
        end
    end

    assign lat_min = lat_min_reg;
    assign lat_max = lat_max_reg;
    assign lat_sum = lat_sum_reg;
`else
    assign lat_min = '0;
    assign lat_max = '0;
    assign lat_sum = '0;
`endif

endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: drives NUM_CH Bambu accelerators in lockstep through a
// configured number of reset/start/done runs, measuring per-channel latency
// and enforcing a per-run watchdog. Optional statistics (min/max/sum) are
// enabled with the HLS_SEQ_STATS_EN macro.
module hls_run_sequencer
    import hls_seq_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RUNS_W  = RUNS_W_DEF,
    parameter int RST_CYC = RST_CYC_DEF,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic [RUNS_W-1:0]        cfg_runs,
    input  logic [CNT_W-1:0]         cfg_timeout,
    output logic [NUM_CH-1:0]        acc_reset,
    output logic [NUM_CH-1:0]        acc_start,
    input  logic [NUM_CH-1:0]        acc_done,
    output logic                     busy,
    output logic                     seq_done,
    output logic [NUM_CH-1:0]        timeout_flag,
    output logic [RUNS_W-1:0]        runs_done,
    input  logic [SEL_W-1:0]         ch_sel,
    output logic [CNT_W-1:0]         lat_last,
    output logic [CNT_W-1:0]         lat_min,
    output logic [CNT_W-1:0]         lat_max,
    output logic [CNT_W+RUNS_W-1:0]  lat_sum
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    seq_state_t         state_reg;
    logic [RUNS_W-1:0]  runs_cfg_reg;
    logic [RUNS_W-1:0]  runs_done_reg;
    logic [RUNS_W-1:0]  runs_done_next;
    logic [CNT_W-1:0]   timeout_cfg_reg;
    logic [CNT_W-1:0]   wd_cnt_reg;
    logic [CNT_W-1:0]   wd_cnt_next;
    logic [RC_W-1:0]    rst_cnt_reg;
    logic [NUM_CH-1:0]  acc_reset_reg;
    logic [NUM_CH-1:0]  acc_start_reg;
    logic [NUM_CH-1:0]  timeout_flag_reg;
    logic [NUM_CH-1:0]  pending_vec;
    logic               busy_reg;
    logic               seq_done_reg;

    logic               accept;
    logic               ch_start;
    logic               ch_wait;
    logic               ch_record;
    logic               all_done;
    logic               wd_fire;

    logic [CNT_W-1:0]         lat_last_arr [NUM_CH];
    logic [CNT_W-1:0]         lat_min_arr  [NUM_CH];
    logic [CNT_W-1:0]         lat_max_arr  [NUM_CH];
    logic [CNT_W+RUNS_W-1:0]  lat_sum_arr  [NUM_CH];

    assign accept    = (state_reg == S_IDLE) && go;
    assign ch_start  = (state_reg == S_START);
    assign ch_wait   = (state_reg == S_WAIT);
    assign ch_record = (state_reg == S_RECORD);
    assign all_done  = ~|pending_vec;

    // The watchdog count in a wait cycle matches the latency a done would
    // record there (start cycle = 1), so a limit of 1 fires in the first
    // wait cycle just as a limit of 2 does.
    assign wd_cnt_next    = CNT_W'(sat_inc(64'(wd_cnt_reg), CNT_W));
    assign wd_fire        = (timeout_cfg_reg != '0) && (wd_cnt_next >= timeout_cfg_reg);
    assign runs_done_next = runs_done_reg + RUNS_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            hls_seq_lat_ch #(
                .CNT_W  (CNT_W),
                .RUNS_W (RUNS_W)
            ) u_lat_ch (
                .clock    (clock),
                .reset    (reset),
                .clear    (accept),
                .start    (ch_start),
                .wait_en  (ch_wait),
                .record   (ch_record),
                .done     (acc_done[gi]),
                .pending  (pending_vec[gi]),
                .lat_last (lat_last_arr[gi]),
                .lat_min  (lat_min_arr[gi]),
                .lat_max  (lat_max_arr[gi]),
                .lat_sum  (lat_sum_arr[gi])
            );
        end
    endgenerate

    // Sequencer FSM with registered accelerator controls and status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            runs_cfg_reg     <= RUNS_W'(1);
            runs_done_reg    <= '0;
            timeout_cfg_reg  <= '0;
            wd_cnt_reg       <= '0;
            rst_cnt_reg      <= '0;
            acc_reset_reg    <= '1;
            acc_start_reg    <= '0;
            timeout_flag_reg <= '0;
            busy_reg         <= 1'b0;
            seq_done_reg     <= 1'b0;
        end else begin
            acc_start_reg <= '0;
            seq_done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        runs_cfg_reg     <= (cfg_runs == '0) ? RUNS_W'(1) : cfg_runs;
                        timeout_cfg_reg  <= cfg_timeout;
                        runs_done_reg    <= '0;
                        timeout_flag_reg <= '0;
                        rst_cnt_reg      <= '0;
                        acc_reset_reg    <= '0;
                        busy_reg         <= 1'b1;
                        state_reg        <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt_reg == RC_W'(RST_CYC - 1)) begin
                        acc_reset_reg <= '1;
                        acc_start_reg <= '1;
                        state_reg     <= S_START;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RC_W'(1);
                    end
                end
                S_START: begin
                    wd_cnt_reg <= CNT_W'(1);
                    state_reg  <= S_WAIT;
                end
                S_WAIT: begin
                    wd_cnt_reg <= wd_cnt_next;
                    if (all_done) begin
                        state_reg <= S_RECORD;
                    end else if (wd_fire) begin
                        timeout_flag_reg <= timeout_flag_reg | pending_vec;
                        busy_reg         <= 1'b0;
                        seq_done_reg     <= 1'b1;
                        state_reg        <= S_END;
                    end
                end
                S_RECORD: begin
                    runs_done_reg <= runs_done_next;
                    if (runs_done_next == runs_cfg_reg) begin
                        busy_reg     <= 1'b0;
                        seq_done_reg <= 1'b1;
                        state_reg    <= S_END;
                    end else begin
                        rst_cnt_reg   <= '0;
                        acc_reset_reg <= '0;
                        state_reg     <= S_RST;
                    end
                end
                S_END: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Statistics read-out mux; out-of-range selects read as zero.
    always_comb begin
        lat_last = '0;
        lat_min  = '0;
        lat_max  = '0;
        lat_sum  = '0;
        if (int'(ch_sel) < NUM_CH) begin
            lat_last = lat_last_arr[ch_sel];
            lat_min  = lat_min_arr[ch_sel];
            lat_max  = lat_max_arr[ch_sel];
            lat_sum  = lat_sum_arr[ch_sel];
        end
    end

    assign acc_reset    = acc_reset_reg;
    assign acc_start    = acc_start_reg;
    assign busy         = busy_reg;
    assign seq_done     = seq_done_reg;
    assign timeout_flag = timeout_flag_reg;
    assign runs_done    = runs_done_reg;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed and randomized sequences for the run
// sequencer, checked against a per-run outcome model (latency = done offset
// + 1, watchdog trips when a channel is still missing at the limit).
// Statistic expectations follow the HLS_SEQ_STATS_EN build setting.
module tb_hls_run_sequencer;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 32;
    localparam int RUNS_W  = 16;
    localparam int RST_CYC = 2;
    localparam int NEVER   = 1000;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    go = 1'b0;
    logic [RUNS_W-1:0]       cfg_runs = '0;
    logic [CNT_W-1:0]        cfg_timeout = '0;
    logic [NUM_CH-1:0]       acc_reset;
    logic [NUM_CH-1:0]       acc_start;
    logic [NUM_CH-1:0]       acc_done = '0;
    logic                    busy;
    logic                    seq_done;
    logic [NUM_CH-1:0]       timeout_flag;
    logic [RUNS_W-1:0]       runs_done;
    logic [0:0]              ch_sel = '0;
    logic [CNT_W-1:0]        lat_last;
    logic [CNT_W-1:0]        lat_min;
    logic [CNT_W-1:0]        lat_max;
    logic [CNT_W+RUNS_W-1:0] lat_sum;

    hls_run_sequencer #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RUNS_W  (RUNS_W),
        .RST_CYC (RST_CYC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .cfg_runs     (cfg_runs),
        .cfg_timeout  (cfg_timeout),
        .acc_reset    (acc_reset),
        .acc_start    (acc_start),
        .acc_done     (acc_done),
        .busy         (busy),
        .seq_done     (seq_done),
        .timeout_flag (timeout_flag),
        .runs_done    (runs_done),
        .ch_sel       (ch_sel),
        .lat_last     (lat_last),
        .lat_min      (lat_min),
        .lat_max      (lat_max),
        .lat_sum      (lat_sum)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int seq_done_cnt = 0;

    // Count seq_done pulses away from the active edge.
    always @(negedge clock) begin
        if (seq_done === 1'b1) seq_done_cnt <= seq_done_cnt + 1;
    end

    // Stimulus: done offset (cycles after start) per run and channel.
    int dly [0:7][0:1];

    // Reference model of the statistics.
    logic [63:0] exp_last [0:1];
    logic [63:0] exp_min  [0:1];
    logic [63:0] exp_max  [0:1];
    logic [63:0] exp_sum  [0:1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int c = 0; c < 2; c++) begin
            exp_last[c] = 0;
            exp_min[c]  = 64'hFFFF_FFFF;
            exp_max[c]  = 0;
            exp_sum[c]  = 0;
        end
    endtask

    task automatic check_stats(input string tag);
        for (int c = 0; c < 2; c++) begin
            ch_sel = c[0:0];
            #1;
            check($sformatf("%s_last_ch%0d", tag, c), 64'(lat_last), exp_last[c]);
`ifdef HLS_SEQ_STATS_EN
            check($sformatf("%s_min_ch%0d", tag, c), 64'(lat_min), exp_min[c]);
            check($sformatf("%s_max_ch%0d", tag, c), 64'(lat_max), exp_max[c]);
            check($sformatf("%s_sum_ch%0d", tag, c), 64'(lat_sum), exp_sum[c]);
`else
            check($sformatf("%s_min_ch%0d", tag, c), 64'(lat_min), 64'd0);
            check($sformatf("%s_max_ch%0d", tag, c), 64'(lat_max), 64'd0);
            check($sformatf("%s_sum_ch%0d", tag, c), 64'(lat_sum), 64'd0);
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_acc_reset"}, 64'(acc_reset), 64'h3);
        check({tag, "_acc_start"}, 64'(acc_start), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_seq_done"}, 64'(seq_done), 64'h0);
        check({tag, "_timeout_flag"}, 64'(timeout_flag), 64'h0);
        check({tag, "_runs_done"}, 64'(runs_done), 64'h0);
        clear_model();
        check_stats(tag);
    endtask

    // Run one sequence; abort_run >= 0 pulls reset in that run's wait phase.
    task automatic run_seq(input string name, input int runs_cfg, input int tmo,
                           input int abort_run, input bit spurious_go, input bit [1:0] extra);
        int eff;
        int base;
        int lows;
        int n;
        int dmax;
        int kt;
        int kend;
        bit timed_out;
        logic [1:0] flags;
        eff  = (runs_cfg == 0) ? 1 : runs_cfg;
        base = seq_done_cnt;
        cfg_runs    = RUNS_W'(runs_cfg);
        cfg_timeout = CNT_W'(tmo);
        go = 1'b1;
        tick();
        go = 1'b0;
        cfg_runs    = RUNS_W'(5);
        cfg_timeout = CNT_W'($urandom_range(1, 3));
        clear_model();
        check({name, "_busy_after_go"}, 64'(busy), 64'h1);
        check_stats({name, "_cleared"});
        for (int r = 0; r < eff; r++) begin
            lows = 0;
            n = 0;
            while (acc_start !== 2'b11 && n < 40) begin
                if (acc_reset === 2'b00) lows++;
                tick();
                n++;
            end
            check($sformatf("%s_r%0d_start", name, r), 64'(acc_start), 64'h3);
            if (acc_start !== 2'b11) return;
            check($sformatf("%s_r%0d_rst_len", name, r), 64'(lows), 64'(RST_CYC));
            dmax = 1;
            for (int c = 0; c < 2; c++) if (dly[r][c] > dmax) dmax = dly[r][c];
            kt = (tmo == 0) ? 2 * NEVER : ((tmo - 1 < 1) ? 1 : tmo - 1);
            timed_out = (dmax > kt);
            kend = timed_out ? kt + 1 : dmax + 2;
            for (int k = 0; k < kend; k++) begin
                if (k > 0) tick();
                for (int c = 0; c < 2; c++)
                    acc_done[c] = (k == dly[r][c]) || (extra[c] && k > dly[r][c]);
                go = (spurious_go && r == 0 && k == 1);
                if (abort_run == r && k == 2) begin
                    reset = 1'b0;
                    tick();
                    reset = 1'b1;
                    acc_done = '0;
                    go = 1'b0;
                    check_reset_state({name, "_abort"});
                    for (int i = 0; i < 4; i++) tick();
                    check({name, "_abort_no_seq_done"}, 64'(seq_done_cnt - base), 64'd0);
                    return;
                end
            end
            tick();
            acc_done = '0;
            go = 1'b0;
            if (timed_out) begin
                for (int c = 0; c < 2; c++) flags[c] = (dly[r][c] > kt);
                check($sformatf("%s_r%0d_to_seq_done", name, r), 64'(seq_done), 64'h1);
                check($sformatf("%s_r%0d_to_busy", name, r), 64'(busy), 64'h0);
                check($sformatf("%s_r%0d_to_flags", name, r), 64'(timeout_flag), 64'(flags));
                check($sformatf("%s_r%0d_to_runs", name, r), 64'(runs_done), 64'(r));
                check_stats($sformatf("%s_r%0d_to", name, r));
                tick();
                check({name, "_seq_done_drop"}, 64'(seq_done), 64'h0);
                check({name, "_one_seq_done"}, 64'(seq_done_cnt - base), 64'd1);
                return;
            end
            for (int c = 0; c < 2; c++) begin
                exp_last[c] = 64'(dly[r][c] + 1);
                if (exp_last[c] < exp_min[c]) exp_min[c] = exp_last[c];
                if (exp_last[c] > exp_max[c]) exp_max[c] = exp_last[c];
                exp_sum[c] = exp_sum[c] + exp_last[c];
            end
            check($sformatf("%s_r%0d_runs", name, r), 64'(runs_done), 64'(r + 1));
            check($sformatf("%s_r%0d_flags", name, r), 64'(timeout_flag), 64'h0);
            check_stats($sformatf("%s_r%0d", name, r));
            if (r == eff - 1) begin
                check({name, "_end_seq_done"}, 64'(seq_done), 64'h1);
                check({name, "_end_busy"}, 64'(busy), 64'h0);
                tick();
                check({name, "_seq_done_drop"}, 64'(seq_done), 64'h0);
                check({name, "_one_seq_done"}, 64'(seq_done_cnt - base), 64'd1);
            end else begin
                check($sformatf("%s_r%0d_mid_seq_done", name, r), 64'(seq_done), 64'h0);
                check($sformatf("%s_r%0d_mid_busy", name, r), 64'(busy), 64'h1);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();

        // Fixed latencies 5 / 10 over three runs.
        for (int r = 0; r < 3; r++) begin dly[r][0] = 4; dly[r][1] = 9; end
        run_seq("fixed", 3, 0, -1, 1'b0, 2'b00);

        // Varying ch0 latency: min 4, max 8, sum 18.
        dly[0][0] = 3; dly[1][0] = 7; dly[2][0] = 5;
        dly[0][1] = 2; dly[1][1] = 2; dly[2][1] = 2;
        run_seq("vary", 3, 0, -1, 1'b0, 2'b00);

        // Watchdog: ch1 never answers, limit 20.
        dly[0][0] = 4; dly[0][1] = NEVER;
        run_seq("wdog", 2, 20, -1, 1'b0, 2'b00);

        // Done already high in the start cycle, extra pulses afterwards.
        dly[0][0] = 0; dly[0][1] = 6;
        run_seq("early", 1, 0, -1, 1'b0, 2'b01);

        // Done and watchdog in the same cycle: done wins.
        dly[0][0] = 5; dly[0][1] = 3;
        run_seq("tie_done", 1, 6, -1, 1'b0, 2'b00);
        dly[0][0] = 6; dly[0][1] = 3;
        run_seq("tie_late", 1, 6, -1, 1'b0, 2'b00);

        // Reset during the wait phase of the second run, then a clean sequence.
        dly[0][0] = 5; dly[0][1] = 6; dly[1][0] = 5; dly[1][1] = 7;
        run_seq("abort", 3, 0, 1, 1'b0, 2'b00);
        dly[0][0] = 3; dly[0][1] = 4; dly[1][0] = 2; dly[1][1] = 3;
        run_seq("after_abort", 2, 0, -1, 1'b0, 2'b00);

        // Zero run count behaves as one; go while busy is ignored.
        dly[0][0] = 3; dly[0][1] = 5;
        run_seq("zero_runs", 0, 0, -1, 1'b1, 2'b00);

        // Randomized sequences.
        for (int s = 0; s < 8; s++) begin
            int runs;
            int tmo;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 2; c++) dly[r][c] = $urandom_range(0, 12);
            runs = $urandom_range(0, 4);
            tmo  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 14);
            run_seq($sformatf("rand%0d", s), runs, tmo, -1, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
